// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns a single-cycle-request MEM-stage data RAM port into an
// sram-like handshake of the form req/addr_ok then data_ok. The pipeline is
// stalled until the response returns.
// Optional feature macro: DATA_SRAM_BRIDGE_FLUSH_EN. When it is defined, a MEM-stage
// flush can drop or discard the in-flight access.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; an enable latches the payload
// REQ    | data_req asserted, waiting for data_addr_ok
// WAIT   | address accepted, waiting for data_data_ok
// DONE   | one-cycle completion, stall released, enable ignored
module data_sram_bridge #(
  parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_wen,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_wdata,
  input  logic [1:0]  data_ram_size,
  input  logic        mem_flush,
  output logic [31:0] data_ram_rdata,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

`ifdef DATA_SRAM_BRIDGE_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state_q, state_d;
  logic   discard_q, discard_d;
  logic   capture;
  logic   flush;

  // Flush is forced low in builds without the flush feature, so the FSM never sees it.
  assign flush = FLUSH_EN & mem_flush;

  // State and discard flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic. A response is dropped when a flush is pending or arrives with it.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_ram_en) state_d = S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            if (discard_q || flush) begin
              state_d   = S_IDLE;
              discard_d = 1'b0;
            end else begin
              capture = ~data_wr;
              state_d = S_DONE;
            end
          end else begin
            state_d = S_WAIT;
            if (flush) discard_d = 1'b1;
          end
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (discard_q || flush) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else begin
            capture = ~data_wr;
            state_d = S_DONE;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request payload, latched once when an access is accepted in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
    end else if (state_q == S_IDLE && data_ram_en) begin
      data_wr    <= |data_ram_wen;
      data_size  <= data_ram_size;
      data_addr  <= data_ram_addr & PADDR_MASK;
      data_wdata <= data_ram_wdata;
    end
  end

  // Load data holding register, written only by a completing load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ram_rdata <= 32'h0;
    end else if (capture) begin
      data_ram_rdata <= data_rdata;
    end
  end

  assign data_req = (state_q == S_REQ);

  // The stall is gated by resetn so that it reads 0 while reset is held, even with the enable high.
  assign mem_stall = resetn & (((state_q == S_IDLE) & data_ram_en) |
                               (state_q == S_REQ) | (state_q == S_WAIT));

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: directed vector table, flush and reset
// sequences, then random transactions against a transaction-level model.
module tb_data_sram_bridge;

`ifdef DATA_SRAM_BRIDGE_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  localparam logic [31:0] MASK = 32'h1FFF_FFFF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic [31:0] data_ram_addr;
  logic [31:0] data_ram_wdata;
  logic [1:0]  data_ram_size;
  logic        mem_flush;
  logic [31:0] data_ram_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  data_sram_bridge dut (
    .clk(clk), .resetn(resetn), .data_ram_en(data_ram_en), .data_ram_wen(data_ram_wen),
    .data_ram_addr(data_ram_addr), .data_ram_wdata(data_ram_wdata),
    .data_ram_size(data_ram_size), .mem_flush(mem_flush),
    .data_ram_rdata(data_ram_rdata), .mem_stall(mem_stall), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          a_dly;     // REQ cycles before the one carrying addr_ok
    int          d_dly;     // cycles from addr_ok to data_ok
    int          flush_k;   // transaction cycle carrying mem_flush, -1 for none
    bit          use_model; // 1: expectations come from the model below
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] cur_rd = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Runs one transaction. The call starts just after a rising edge and returns just after the rising edge that follows its last cycle.
  task automatic run_txn(input vec_t v_in);
    vec_t v;
    int   ka, kd, term;
    bit   drop, disc, is_load, is_done, exp_req;
    v       = v_in;
    ka      = 1 + v.a_dly;
    kd      = ka + v.d_dly;
    drop    = FLUSH && v.flush_k >= 1 && v.flush_k < ka;
    disc    = FLUSH && v.flush_k >= ka && v.flush_k <= kd;
    is_load = (v.wen == 4'h0);
    if (v.use_model) begin
      v.exp_addr = v.addr & MASK;
      v.exp_rd   = (is_load && !drop && !disc) ? v.rdata : cur_rd;
    end
    term = drop ? v.flush_k : (disc ? kd : kd + 1);
    for (int k = 0; k <= term; k++) begin
      is_done        = !drop && !disc && (k == kd + 1);
      data_ram_en    = !((drop || disc) && k > v.flush_k);
      data_ram_wen   = v.wen;
      data_ram_size  = v.size;
      data_ram_addr  = v.addr;
      data_ram_wdata = v.wdata;
      mem_flush      = (k == v.flush_k);
      if (k == 0 || is_done) begin
        data_addr_ok = 1'($urandom_range(0, 1));
        data_data_ok = 1'($urandom_range(0, 1));
      end else begin
        data_addr_ok = (k == ka);
        data_data_ok = (k == kd);
      end
      data_rdata = (k == kd) ? v.rdata : $urandom;
      @(negedge clk);
      exp_req = (k >= 1 && k <= ka);
      chk("mem_stall", 32'(mem_stall), 32'(!is_done));
      chk("data_req", 32'(data_req), 32'(exp_req));
      if (exp_req) begin
        chk("data_addr", data_addr, v.exp_addr);
        chk("data_wr", 32'(data_wr), 32'(!is_load));
        chk("data_size", 32'(data_size), 32'(v.size));
        chk("data_wdata", data_wdata, v.wdata);
      end
      chk("data_ram_rdata", data_ram_rdata, is_done ? v.exp_rd : cur_rd);
      @(posedge clk);
      #1;
    end
    cur_rd = v.exp_rd;
  endtask

  // Idle cycles: no enable, spurious acks and flushes must do nothing.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data_ram_en  = 1'b0;
      mem_flush    = 1'($urandom_range(0, 1));
      data_addr_ok = 1'($urandom_range(0, 1));
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata   = $urandom;
      @(negedge clk);
      chk("idle_stall", 32'(mem_stall), 32'h0);
      chk("idle_req", 32'(data_req), 32'h0);
      chk("idle_rdata", data_ram_rdata, cur_rd);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(data_req), 32'h0);
    chk({tag, "_wr"}, 32'(data_wr), 32'h0);
    chk({tag, "_size"}, 32'(data_size), 32'h0);
    chk({tag, "_addr"}, data_addr, 32'h0);
    chk({tag, "_wdata"}, data_wdata, 32'h0);
    chk({tag, "_rdata"}, data_ram_rdata, 32'h0);
    chk({tag, "_stall"}, 32'(mem_stall), 32'h0);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int   t, lane;
    t    = $urandom_range(0, 3);
    lane = $urandom_range(0, 3);
    case (t)
      0:       begin v.wen = 4'h0;                         v.size = 2'($urandom_range(0, 2)); end
      1:       begin v.wen = 4'(1 << lane);                v.size = 2'd0; end
      2:       begin v.wen = lane[1] ? 4'b1100 : 4'b0011;  v.size = 2'd1; end
      default: begin v.wen = 4'hF;                         v.size = 2'd2; end
    endcase
    v.addr      = $urandom;
    v.wdata     = $urandom;
    v.rdata     = $urandom;
    v.a_dly     = $urandom_range(0, 3);
    v.d_dly     = $urandom_range(0, 3);
    v.flush_k   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 1 + v.a_dly + v.d_dly) : -1;
    v.use_model = 1'b1;
    v.exp_addr  = 32'h0;
    v.exp_rd    = 32'h0;
    return v;
  endfunction

  vec_t dir_tab[6];
  vec_t flush_tab[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_tab[0] = '{4'h0, 2'd2, 32'h8000_1000, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, -1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF};
    dir_tab[1] = '{4'b0100, 2'd0, 32'hA000_0002, 32'h00AB_0000, 32'h5555_5555, 3, 2, -1, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF};
    dir_tab[2] = '{4'h0, 2'd1, 32'h9FFF_FFFE, 32'h0, 32'h0000_CAFE, 1, 0, -1, 1'b0, 32'h1FFF_FFFE, 32'h0000_CAFE};
    dir_tab[3] = '{4'h0, 2'd0, 32'h0000_0003, 32'h0, 32'h1122_3344, 0, 3, -1, 1'b0, 32'h0000_0003, 32'h1122_3344};
    dir_tab[4] = '{4'hF, 2'd2, 32'hBFC0_0010, 32'hCAFE_F00D, 32'h7777_7777, 0, 0, -1, 1'b0, 32'h1FC0_0010, 32'h1122_3344};
    dir_tab[5] = '{4'h0, 2'd2, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_0F0F, 2, 1, -1, 1'b0, 32'h1FFF_FFFC, 32'hA5A5_0F0F};

    flush_tab[0] = '{4'h0, 2'd2, 32'h8000_2000, 32'h0, 32'h1234_5678, 0, 3, 2, 1'b1, 32'h0, 32'h0};
    flush_tab[1] = '{4'h0, 2'd2, 32'h8000_2004, 32'h0, 32'h2222_2222, 3, 0, 1, 1'b1, 32'h0, 32'h0};
    flush_tab[2] = '{4'h0, 2'd1, 32'h8000_2008, 32'h0, 32'h3333_3333, 1, 1, 2, 1'b1, 32'h0, 32'h0};
    flush_tab[3] = '{4'h0, 2'd2, 32'h8000_200C, 32'h0, 32'h4444_4444, 0, 0, 1, 1'b1, 32'h0, 32'h0};
    flush_tab[4] = '{4'h0, 2'd2, 32'h8000_2010, 32'h0, 32'h5A5A_5A5A, 0, 0, -1, 1'b1, 32'h0, 32'h0};

    resetn = 1'b0; data_ram_en = 1'b0; data_ram_wen = 4'h0; data_ram_addr = 32'h0;
    data_ram_wdata = 32'h0; data_ram_size = 2'd0; mem_flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    @(negedge clk);
    check_all_zero("rst");
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors back to back, with no gap between transactions.
    for (int i = 0; i < 6; i++) run_txn(dir_tab[i]);
    idle(2);

    // Flush cases (ignored when the flush feature is not built in).
    for (int i = 0; i < 5; i++) run_txn(flush_tab[i]);
    idle(1);

    // Reset while in WAIT, then a late data_ok.
    data_ram_en = 1'b1; data_ram_wen = 4'h0; data_ram_size = 2'd2;
    data_ram_addr = 32'h8000_0040; mem_flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("wait_stall", 32'(mem_stall), 32'h1);
    chk("wait_req", 32'(data_req), 32'h0);
    #1 resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    data_ram_en = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("late_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    check_all_zero("late");
    cur_rd = 32'h0;
    @(posedge clk); #1;

    // Random transactions, with idle gaps of random length between them.
    for (int i = 0; i < 80; i++) begin
      run_txn(rand_vec());
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
